// File: rtl/spi_controller.sv
// SPI host, mode 0 (CPOL=0, CPHA=0), MSB first, active-low chip select.
// Bytes arrive on a valid/ready stream. Bursts keep CS low until a byte flagged last has been sent.
module spi_controller #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_DIV    = 4,
  parameter int CS_GAP     = 2
) (
  input  logic                  sys_clock_i,
  input  logic                  sys_reset_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic                  tx_last_i,
  input  logic                  tx_valid_i,
  output logic                  tx_ready_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic                  rx_valid_o,
  output logic                  busy_o,
  output logic                  spi_clock_o,
  output logic                  spi_cs_o,
  output logic                  spi_pico_o,
  input  logic                  spi_poci_i
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(DATA_WIDTH + 1);
  localparam int GAP_W = (CS_GAP > 2) ? $clog2(CS_GAP - 1) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((CS_GAP >= 2) ? (CS_GAP - 2) : 0);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_WAIT,
    S_TAIL,
    S_GAP
  } state_t;

  state_t                state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic [DATA_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_WIDTH-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
  logic                  last_q, last_d;
  logic                  sclk_q, sclk_d;
  logic                  cs_q, cs_d;
  logic                  pico_q, pico_d;
  logic                  ready_q, ready_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  busy_q, busy_d;
  logic                  accept;

  assign accept = tx_valid_i & ready_q;

  always_comb begin
    state_d    = state_q;
    div_cnt_d  = div_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    last_d     = last_q;
    sclk_d     = sclk_q;
    cs_d       = cs_q;
    pico_d     = pico_q;
    ready_d    = ready_q;
    rx_valid_d = 1'b0;

    case (state_q)
      S_IDLE, S_WAIT: begin
        // In WAIT, ready rises one cycle after rx_valid, never in the same cycle.
        ready_d = 1'b1;
        if (state_q == S_IDLE) begin
          cs_d   = 1'b1;
          sclk_d = 1'b0;
        end
        if (accept) begin
          state_d    = S_LEAD;
          tx_shift_d = tx_data_i;
          last_d     = tx_last_i;
          pico_d     = tx_data_i[DATA_WIDTH-1];
          cs_d       = 1'b0;
          sclk_d     = 1'b0;
          ready_d    = 1'b0;
          div_cnt_d  = '0;
          bit_cnt_d  = '0;
        end
      end

      S_LEAD: begin
        if (div_cnt_q == DIV_LAST) begin
          state_d    = S_SHIFT;
          div_cnt_d  = '0;
          sclk_d     = 1'b1;
          rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(spi_poci_i);
          bit_cnt_d  = bit_cnt_q + 1'b1;
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          if (!sclk_q) begin
            // Rising SCLK: capture poci in the same system edge that raises the clock.
            sclk_d     = 1'b1;
            rx_shift_d = (rx_shift_q << 1) | DATA_WIDTH'(spi_poci_i);
            bit_cnt_d  = bit_cnt_q + 1'b1;
          end else begin
            sclk_d = 1'b0;
            if (bit_cnt_q == BIT_LAST) begin
              rx_data_d  = rx_shift_q;
              rx_valid_d = 1'b1;
              state_d    = last_q ? S_TAIL : S_WAIT;
            end else begin
              tx_shift_d = tx_shift_q << 1;
              pico_d     = tx_shift_d[DATA_WIDTH-1];
            end
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_TAIL: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d = '0;
          cs_d      = 1'b1;
          // The first IDLE cycle still has CS high, so it counts toward the gap.
          if (CS_GAP == 1) begin
            state_d = S_IDLE;
            ready_d = 1'b1;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = '0;
          end
        end else begin
          div_cnt_d = div_cnt_q + 1'b1;
        end
      end

      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          state_d = S_IDLE;
          ready_d = 1'b1;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        cs_d    = 1'b1;
        sclk_d  = 1'b0;
        ready_d = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge sys_clock_i) begin
    if (sys_reset_i) begin
      state_q    <= S_IDLE;
      div_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b0;
      sclk_q     <= 1'b0;
      cs_q       <= 1'b1;
      pico_q     <= 1'b0;
      ready_q    <= 1'b1;
      rx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      div_cnt_q  <= div_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
      sclk_q     <= sclk_d;
      cs_q       <= cs_d;
      pico_q     <= pico_d;
      ready_q    <= ready_d;
      rx_valid_q <= rx_valid_d;
      busy_q     <= busy_d;
    end
  end

  assign tx_ready_o  = ready_q;
  assign rx_data_o   = rx_data_q;
  assign rx_valid_o  = rx_valid_q;
  assign busy_o      = busy_q;
  assign spi_clock_o = sclk_q;
  assign spi_cs_o    = cs_q;
  assign spi_pico_o  = pico_q;

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: vector table of single-byte frames plus burst, stall, abort and gap sequences.
// Received bytes are checked against a scoreboard queue filled when stimulus is issued.
module tb_spi_controller;
  localparam int DW  = 8;
  localparam int CD  = 2;
  localparam int GAP = 2;

  logic          clk = 1'b0;
  logic          srst;
  logic [DW-1:0] tx_data;
  logic          tx_last;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          busy;
  logic          sclk;
  logic          cs;
  logic          pico;
  logic          poci;

  spi_controller #(.DATA_WIDTH(DW), .CLK_DIV(CD), .CS_GAP(GAP)) dut (
    .sys_clock_i(clk),
    .sys_reset_i(srst),
    .tx_data_i(tx_data),
    .tx_last_i(tx_last),
    .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready),
    .rx_data_o(rx_data),
    .rx_valid_o(rx_valid),
    .busy_o(busy),
    .spi_clock_o(sclk),
    .spi_cs_o(cs),
    .spi_pico_o(pico),
    .spi_poci_i(poci)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Target model (mode 0): first bit on CS fall, next bit on each SCLK fall.
  bit            loop_mode = 1'b1;
  logic [DW-1:0] tgt_bytes [2];
  logic [DW-1:0] tgt_shift = '0;
  int            tgt_bits = 0;
  int            tgt_idx = 0;
  assign poci = loop_mode ? pico : tgt_shift[DW-1];

  bit            sclk_p = 1'b0;
  bit            cs_p = 1'b1;
  int            rise_cnt = 0, first_rise_cyc = 0, rx_cnt = 0, rx_cyc = 0;
  int            low_run = 0, high_run = 0, last_low_run = 0, last_high_run = 0, cs_rise_cnt = 0;
  logic [15:0]   pico_cap = '0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] exp_b;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (sclk && !sclk_p) begin
      rise_cnt++;
      if (rise_cnt == 1) first_rise_cyc = cyc;
      pico_cap = {pico_cap[14:0], pico};
      tgt_bits++;
    end
    if (!sclk && sclk_p) begin
      if (tgt_bits == DW) begin
        tgt_shift = tgt_bytes[tgt_idx];
        tgt_idx   = 1;
        tgt_bits  = 0;
      end else begin
        tgt_shift = tgt_shift << 1;
      end
    end
    if (!cs && cs_p) begin
      last_high_run = high_run;
      low_run       = 0;
      tgt_shift     = tgt_bytes[0];
      tgt_idx       = 1;
      tgt_bits      = 0;
    end
    if (cs && !cs_p) begin
      last_low_run = low_run;
      high_run     = 0;
      cs_rise_cnt++;
    end
    if (cs) high_run++;
    else low_run++;
    if (rx_valid) begin
      rx_cnt++;
      rx_cyc = cyc;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got=%0h want=none (cyc %0d)", rx_data, cyc);
      end else begin
        exp_b = exp_q.pop_front();
        chk("rx_data", 32'(rx_data), 32'(exp_b));
      end
    end
    sclk_p = sclk;
    cs_p   = cs;
  end

  // Returns the index of the accepting edge (cyc value seen on the following negedge).
  task automatic send(input logic [DW-1:0] d, input logic l, input bit keep, output int a);
    int n;
    n        = 0;
    tx_data  = d;
    tx_last  = l;
    tx_valid = 1'b1;
    while (!tx_ready && n < 500) begin
      tick();
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: got ready=%0b want ready=1 (cyc %0d)", tx_ready, cyc);
      a        = cyc;
      tx_valid = 1'b0;
    end else begin
      a = cyc + 1;
      tick();
      if (!keep) tx_valid = 1'b0;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    tick();
    while (!(cs && !busy) && n < 2000) begin
      tick();
      n++;
    end
    chk("idle_timeout", 32'(cs && !busy), 32'd1);
  endtask

  typedef struct {
    logic [DW-1:0] tx;
    bit            loop;
    logic [DW-1:0] tgt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int a, a1, a2, rx0, cr0, n;
    bit stall_ok;
    logic [DW-1:0] e;

    vecs[0] = '{tx: 8'hA5, loop: 1'b1, tgt: 8'h00};
    vecs[1] = '{tx: 8'h00, loop: 1'b1, tgt: 8'h00};
    vecs[2] = '{tx: 8'hFF, loop: 1'b1, tgt: 8'h00};
    vecs[3] = '{tx: 8'h3C, loop: 1'b0, tgt: 8'h81};
    vecs[4] = '{tx: 8'h96, loop: 1'b0, tgt: 8'h7E};
    tgt_bytes[0] = '0;
    tgt_bytes[1] = '0;

    // Reset held with tx_valid high: nothing may be accepted.
    srst     = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'hA5;
    tx_last  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("reset_outs", 32'({cs, sclk, pico, tx_ready, rx_valid, busy}), 32'b100100);
    end
    chk("reset_rxdata", 32'(rx_data), 32'd0);
    srst     = 1'b0;
    tx_valid = 1'b0;
    tick();
    tick();
    chk("post_reset_idle", 32'({cs, busy}), 32'b10);

    // Single-byte frames with full timing checks.
    for (int i = 0; i < 5; i++) begin
      loop_mode    = vecs[i].loop;
      tgt_bytes[0] = vecs[i].tgt;
      e            = vecs[i].loop ? vecs[i].tx : vecs[i].tgt;
      rise_cnt     = 0;
      rx0          = rx_cnt;
      exp_q.push_back(e);
      send(vecs[i].tx, 1'b1, 1'b0, a);
      wait_idle();
      chk("rises", 32'(rise_cnt), 32'(DW));
      chk("pico_bits", 32'(pico_cap[7:0]), 32'(vecs[i].tx));
      chk("first_rise", 32'(first_rise_cyc - a), 32'(CD));
      chk("rx_valid_at", 32'(rx_cyc - a), 32'(2 * DW * CD));
      chk("cs_low_len", 32'(last_low_run), 32'(2 * DW * CD + CD));
      chk("rx_pulses", 32'(rx_cnt - rx0), 32'd1);
    end

    // Two-byte burst against the target model.
    loop_mode    = 1'b0;
    tgt_bytes[0] = 8'h12;
    tgt_bytes[1] = 8'h34;
    rise_cnt     = 0;
    rx0          = rx_cnt;
    cr0          = cs_rise_cnt;
    exp_q.push_back(8'h12);
    exp_q.push_back(8'h34);
    send(8'h3C, 1'b0, 1'b0, a1);
    send(8'hC3, 1'b1, 1'b0, a2);
    chk("ready_after_rx", 32'(a2 - rx_cyc), 32'd2);
    wait_idle();
    chk("burst_rises", 32'(rise_cnt), 32'(2 * DW));
    chk("burst_pico", 32'(pico_cap), 32'h3CC3);
    chk("burst_rx_pulses", 32'(rx_cnt - rx0), 32'd2);
    chk("burst_cs_rises", 32'(cs_rise_cnt - cr0), 32'd1);

    // Burst with a 20-cycle stall between bytes.
    loop_mode = 1'b1;
    rise_cnt  = 0;
    cr0       = cs_rise_cnt;
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    send(8'h11, 1'b0, 1'b0, a1);
    n = 0;
    while (!rx_valid && n < 500) begin
      tick();
      n++;
    end
    chk("stall_rx_seen", 32'(rx_valid), 32'd1);
    stall_ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cs !== 1'b0 || sclk !== 1'b0 || tx_ready !== 1'b1) stall_ok = 1'b0;
    end
    chk("stall_hold", 32'(stall_ok), 32'd1);
    send(8'h22, 1'b1, 1'b0, a2);
    chk("stall_accept", 32'(a2 - rx_cyc), 32'd21);
    wait_idle();
    chk("stall_pico", 32'(pico_cap), 32'h1122);
    chk("stall_cs_rises", 32'(cs_rise_cnt - cr0), 32'd1);

    // Reset after the third rising SCLK aborts the frame.
    rise_cnt = 0;
    rx0      = rx_cnt;
    send(8'h77, 1'b1, 1'b0, a);
    n = 0;
    while (rise_cnt < 3 && n < 500) begin
      tick();
      n++;
    end
    srst = 1'b1;
    tick();
    chk("abort_outs", 32'({cs, sclk, rx_valid, busy, tx_ready}), 32'b10001);
    chk("abort_rxdata", 32'(rx_data), 32'd0);
    srst = 1'b0;
    for (int i = 0; i < 40; i++) tick();
    chk("abort_no_rx", 32'(rx_cnt - rx0), 32'd0);
    rise_cnt = 0;
    rx0      = rx_cnt;
    exp_q.push_back(8'h5A);
    send(8'h5A, 1'b1, 1'b0, a);
    wait_idle();
    chk("after_abort_pico", 32'(pico_cap[7:0]), 32'h5A);
    chk("after_abort_rises", 32'(rise_cnt), 32'(DW));
    chk("after_abort_rx", 32'(rx_cnt - rx0), 32'd1);

    // tx_valid held high across two last bytes: second waits out the CS gap.
    exp_q.push_back(8'hE1);
    exp_q.push_back(8'h1E);
    send(8'hE1, 1'b1, 1'b1, a1);
    send(8'h1E, 1'b1, 1'b0, a2);
    wait_idle();
    chk("gap_high_len", 32'(last_high_run), 32'(GAP));
    chk("gap_accept", 32'(a2 - a1), 32'(2 * DW * CD + CD + GAP));
    chk("gap_pico", 32'(pico_cap), 32'hE11E);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout want=finish (cyc %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
